// File: rtl/lut_scan_sequencer.sv
// Walks row index j from 0 to a latched j_last, emitting one BRAM bank/address beat per row,
// and flags read data READ_LATENCY cycles after each beat. Optional feature: SCAN_ABORT_EN adds an abort input.
module lut_scan_sequencer #(
  parameter int BRAM_NUMBER_SIZE  = 5,
  parameter int BRAM_ADDRESS_SIZE = 8,
  parameter int J_SIZE            = 9,
  parameter int X_SIZE            = 3,
  parameter int READ_LATENCY      = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [X_SIZE-1:0]            x_enc,
  input  logic [J_SIZE-1:0]            j_last,
`ifdef SCAN_ABORT_EN
  input  logic                         abort,
`endif
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BRAM_NUMBER_SIZE-1:0]  bram_number,
  output logic [BRAM_ADDRESS_SIZE-1:0] bram_address,
  output logic                         rd_valid,
  output logic                         done
);

  localparam int HI_SIZE = BRAM_ADDRESS_SIZE - X_SIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                       state_reg, state_next;
  logic [J_SIZE-1:0]            j_reg, j_next;
  logic [J_SIZE-1:0]            j_inc;
  logic [J_SIZE-1:0]            j_last_reg, j_last_next;
  logic [X_SIZE-1:0]            x_enc_reg, x_enc_next;
  logic                         out_valid_reg, out_valid_next;
  logic [BRAM_NUMBER_SIZE-1:0]  bram_number_reg, bram_number_next;
  logic [BRAM_ADDRESS_SIZE-1:0] bram_address_reg, bram_address_next;
  logic                         busy_reg, busy_next;
  logic                         done_reg, done_next;
  logic [READ_LATENCY-1:0]      rd_pipe_reg, rd_pipe_next;
  logic                         issue;
  logic                         abort_req;

  // Upper row bits select the LUT page; the code picks the entry inside it.
  function automatic logic [BRAM_ADDRESS_SIZE-1:0] addr_of(
    input logic [J_SIZE-1:0] j,
    input logic [X_SIZE-1:0] x
  );
    return {j[J_SIZE-1 -: HI_SIZE], x};
  endfunction

`ifdef SCAN_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign issue = out_valid_reg && out_ready;
  assign j_inc = j_reg + J_SIZE'(1);

  // One stage per cycle of BRAM latency; the last stage marks returning data.
  assign rd_pipe_next[0] = issue;
  genvar gi;
  generate
    for (gi = 1; gi < READ_LATENCY; gi++) begin : g_rd_pipe
      assign rd_pipe_next[gi] = rd_pipe_reg[gi-1];
    end
  endgenerate

  always_comb begin
    state_next        = state_reg;
    j_next            = j_reg;
    j_last_next       = j_last_reg;
    x_enc_next        = x_enc_reg;
    out_valid_next    = out_valid_reg;
    bram_number_next  = bram_number_reg;
    bram_address_next = bram_address_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next        = ISSUE;
          x_enc_next        = x_enc;
          j_last_next       = j_last;
          j_next            = '0;
          out_valid_next    = 1'b1;
          bram_number_next  = '0;
          bram_address_next = addr_of('0, x_enc);
        end
      end
      ISSUE: begin
        if (abort_req) begin
          state_next     = DRAIN;
          out_valid_next = 1'b0;
        end else if (issue) begin
          // Compare before incrementing so a full-range scan never wraps j.
          if (j_reg == j_last_reg) begin
            state_next     = DRAIN;
            out_valid_next = 1'b0;
          end else begin
            j_next            = j_inc;
            bram_number_next  = j_inc[BRAM_NUMBER_SIZE-1:0];
            bram_address_next = addr_of(j_inc, x_enc_reg);
          end
        end
      end
      DRAIN: begin
        // Leave once the final read is being returned, so done follows it by one cycle.
        if (rd_pipe_next == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next     = IDLE;
        out_valid_next = 1'b0;
      end
    endcase

    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= IDLE;
      j_reg            <= '0;
      j_last_reg       <= '0;
      x_enc_reg        <= '0;
      out_valid_reg    <= 1'b0;
      bram_number_reg  <= '0;
      bram_address_reg <= '0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      rd_pipe_reg      <= '0;
    end else begin
      state_reg        <= state_next;
      j_reg            <= j_next;
      j_last_reg       <= j_last_next;
      x_enc_reg        <= x_enc_next;
      out_valid_reg    <= out_valid_next;
      bram_number_reg  <= bram_number_next;
      bram_address_reg <= bram_address_next;
      busy_reg         <= busy_next;
      done_reg         <= done_next;
      rd_pipe_reg      <= rd_pipe_next;
    end
  end

  assign busy         = busy_reg;
  assign out_valid    = out_valid_reg;
  assign bram_number  = bram_number_reg;
  assign bram_address = bram_address_reg;
  assign rd_valid     = rd_pipe_reg[READ_LATENCY-1];
  assign done         = done_reg;

endmodule

// File: doc/lut_scan_sequencer.md
LUT_SCAN_SEQUENCER -- requirements
Module: lut_scan_sequencer

Interface
REQ-001 SHALL have parameter BRAM_NUMBER_SIZE, default 5, width of the BRAM bank select.
REQ-002 SHALL have parameter BRAM_ADDRESS_SIZE, default 8, width of the in-bank address.
REQ-003 SHALL have parameter J_SIZE, default 9, width of the row index j.
REQ-004 SHALL have parameter X_SIZE, default 3, width of the encoded sub-vector code x_enc.
REQ-005 SHALL have parameter READ_LATENCY, default 2, BRAM read latency in cycles, legal range 1..4.
REQ-006 SHALL use one clock and a synchronous, active-high reset:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
REQ-007 SHALL have these ports:
- start  in  1  one-cycle scan request
- x_enc  in  X_SIZE  code, sampled on an accepted start
- j_last  in  J_SIZE  last row index, sampled on an accepted start
- busy  out  1  scan in progress
- out_valid  out  1  address beat valid
- out_ready  in  1  downstream accepts the beat
- bram_number  out  BRAM_NUMBER_SIZE  bank select
- bram_address  out  BRAM_ADDRESS_SIZE  in-bank address
- rd_valid  out  1  read data for an issued beat is due this cycle
- done  out  1  one-cycle scan-complete pulse

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, DRAIN and DONE.
REQ-009 In IDLE, start SHALL be accepted: latch x_enc and j_last, clear j to 0, go to ISSUE, and raise busy on the next cycle.
REQ-010 In ISSUE, out_valid SHALL be 1, with bram_number = j[BRAM_NUMBER_SIZE-1:0] and bram_address = {j[J_SIZE-1 -: BRAM_ADDRESS_SIZE-X_SIZE], latched x_enc}.
REQ-011 A beat SHALL issue only when out_valid and out_ready are both 1; on issue, j increments by 1.
REQ-012 While out_ready=0, j, bram_number and bram_address SHALL hold stable and out_valid SHALL stay 1.
REQ-013 Issuing the beat with j == latched j_last SHALL move the FSM to DRAIN, with no increment past j_last and no wrap.
REQ-014 rd_valid SHALL assert exactly READ_LATENCY cycles after each issued beat, via a READ_LATENCY-deep shift register.
REQ-015 In DRAIN, the FSM SHALL wait until the shift register is all zero, then go to DONE.
REQ-016 DONE SHALL last one cycle with done=1, then return to IDLE; busy SHALL fall in the cycle after DONE.
REQ-017 busy SHALL be 1 in ISSUE, DRAIN and DONE, and 0 in IDLE.
REQ-018 start SHALL be ignored whenever the FSM is not in IDLE, with no effect on the scan in progress.
REQ-019 j_last = 0 SHALL produce exactly one beat.
REQ-020 j_last = 2^J_SIZE-1 SHALL produce 2^J_SIZE beats; the j counter SHALL be J_SIZE+1 bits or otherwise compare before incrementing, so that no wrap occurs.
REQ-021 Outputs SHALL be registered; out_valid SHALL rise the cycle after start is accepted.

Reset
REQ-022 Reset SHALL force the FSM to IDLE, clear j and the latched registers to 0, and clear the rd_valid shift register.
REQ-023 During and after reset, busy, out_valid, rd_valid and done SHALL be 0, and bram_number and bram_address SHALL be 0.
REQ-024 Reset mid-scan SHALL discard all outstanding beats with no done pulse; start in the same cycle as reset SHALL be ignored.

Configuration
REQ-025 Macro SCAN_ABORT_EN SHALL, when defined, add input abort (1 bit).
REQ-026 With SCAN_ABORT_EN defined, abort=1 in ISSUE SHALL drop out_valid on the next cycle, issue no further beats, and go to DRAIN; done then fires normally after outstanding reads return. abort SHALL have no effect in IDLE, DRAIN and DONE.
REQ-027 Without SCAN_ABORT_EN, the abort port SHALL be absent and every scan SHALL run to j_last.

Verification
REQ-028 start, x_enc=5, j_last=3, out_ready=1 SHALL give 4 consecutive beats, j=0..3, with bram_address[2:0]=5, rd_valid 2 cycles after each beat, and done one cycle after the last rd_valid.
REQ-029 j=0x1A3 SHALL give bram_number=0x03 and bram_address={5'b11010, x_enc}; 2^9 beats with j_last=511 SHALL end with no wrap.
REQ-030 out_ready low for 3 cycles at j=2 SHALL hold outputs stable; the total beat count SHALL still be j_last+1.
REQ-031 start pulsed during ISSUE SHALL cause no restart; the latched x_enc and j_last SHALL be unchanged.
REQ-032 reset asserted at j=1 with 2 reads outstanding SHALL give all outputs 0 next cycle and no done pulse.
REQ-033 With SCAN_ABORT_EN defined, abort at j=2 SHALL give beats 0..1 (plus beat 2 if issued that cycle), pending rd_valid pulses, then done.
